// File: rtl/decrypt_pkg.sv
// Shared constants and channel encodings for the decrypt demultiplexer.
package decrypt_pkg;

    localparam int         D_WIDTH = 8;
    localparam logic [7:0] TERM    = 8'hFA;

    // Routing tag stored alongside every buffered byte.
    typedef enum logic [1:0] {
        CH_0       = 2'd0,
        CH_1       = 2'd1,
        CH_2       = 2'd2,
        CH_DISCARD = 2'd3
    } chan_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and occupancy count.
// Writes are refused while full, even if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_do;
    logic             rd_do;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_do   = wr_en && !full;
    assign rd_do   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted pushes only.
    // NOTE: the data array is deliberately not reset; the count and pointers
    // alone define what is valid, and resetting storage costs flops for nothing.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_do) wr_ptr <= wr_ptr + 1'b1;
            if (rd_do) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_do, rd_do})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decrypt_demux.sv
// Buffers ciphertext bytes tagged with their message's channel and routes
// them in order to one of three decryptors, or discards them.
// rst_n is a synchronous, active-high reset despite its name.
module decrypt_demux #(
    parameter int                 D_WIDTH    = decrypt_pkg::D_WIDTH,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [D_WIDTH-1:0] TERM       = decrypt_pkg::TERM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         select_i,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    output logic               busy_o,
    output logic [D_WIDTH-1:0] data0_o,
    output logic [D_WIDTH-1:0] data1_o,
    output logic [D_WIDTH-1:0] data2_o,
    output logic               valid0_o,
    output logic               valid1_o,
    output logic               valid2_o,
    input  logic               busy0_i,
    input  logic               busy1_i,
    input  logic               busy2_i
);

    import decrypt_pkg::*;

    localparam int EW = D_WIDTH + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               in_msg;
    chan_e              cur_tag;
    chan_e              wr_tag;
    chan_e              head_tag;
    logic [D_WIDTH-1:0] head_data;
    logic [EW-1:0]      rd_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               wr_accept;
    logic               pop;

    // First byte of a message takes the live select; later bytes reuse it.
    assign wr_tag    = in_msg ? cur_tag : chan_e'(select_i);
    assign wr_accept = valid_i && !fifo_full;
    assign head_tag  = chan_e'(rd_entry[EW-1 -: 2]);
    assign head_data = rd_entry[D_WIDTH-1:0];
    assign busy_o    = (fifo_count == CW'(FIFO_DEPTH));

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (valid_i),
        .wr_data ({wr_tag, data_i}),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Track message boundaries on the write side; dropped bytes do not count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            in_msg  <= 1'b0;
            cur_tag <= CH_0;
        end else if (wr_accept) begin
            in_msg  <= (data_i != TERM);
            cur_tag <= wr_tag;
        end
    end

    // Head-of-line arbitration: pop when the head's target can take it.
    // NOTE: pop gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            case (head_tag)
                CH_0:       pop = !busy0_i;
                CH_1:       pop = !busy1_i;
                CH_2:       pop = !busy2_i;
                CH_DISCARD: pop = 1'b1;
                default:    pop = 1'b0;
            endcase
        end
    end

    // Registered outputs: one-cycle strobe on the popped channel, zeros elsewhere.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid0_o <= 1'b0;
            valid1_o <= 1'b0;
            valid2_o <= 1'b0;
            data0_o  <= '0;
            data1_o  <= '0;
            data2_o  <= '0;
        end else begin
            valid0_o <= 1'b0;
            valid1_o <= 1'b0;
            valid2_o <= 1'b0;
            data0_o  <= '0;
            data1_o  <= '0;
            data2_o  <= '0;
            if (pop) begin
                case (head_tag)
                    CH_0: begin
                        valid0_o <= 1'b1;
                        data0_o  <= head_data;
                    end
                    CH_1: begin
                        valid1_o <= 1'b1;
                        data1_o  <= head_data;
                    end
                    CH_2: begin
                        valid2_o <= 1'b1;
                        data2_o  <= head_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decrypt_demux.sv
// Scoreboard bench for decrypt_demux: stimulus pushes expected {channel, byte}
// entries, a negedge monitor pops and compares whenever a strobe appears.
module tb_decrypt_demux;

    localparam logic [7:0] T = 8'hFA;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] select_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       busy_o;
    logic [7:0] data0_o, data1_o, data2_o;
    logic       valid0_o, valid1_o, valid2_o;
    logic       busy0_i, busy1_i, busy2_i;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    decrypt_demux dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .select_i (select_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .busy_o   (busy_o),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .valid0_o (valid0_o),
        .valid1_o (valid1_o),
        .valid2_o (valid2_o),
        .busy0_i  (busy0_i),
        .busy1_i  (busy1_i),
        .busy2_i  (busy2_i)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic put(input logic [1:0] sel, input logic [7:0] d, input bit push, input logic [1:0] ch);
        @(posedge clk); #1;
        select_i = sel;
        data_i   = d;
        valid_i  = 1'b1;
        if (push) sb.push_back('{ch: ch, data: d});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic quiet(input string name);
        check({name, "_v0"}, valid0_o, 1'b0);
        check({name, "_v1"}, valid1_o, 1'b0);
        check({name, "_v2"}, valid2_o, 1'b0);
        check({name, "_d"}, {data0_o, data1_o, data2_o}, 24'h0);
        check({name, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        check({name, "_drain"}, sb.size(), 0);
        idle(4);
    endtask

    // Monitor: compare every strobe against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n === 1'b0) begin
            check("one_strobe", (valid0_o + valid1_o + valid2_o) <= 1, 1'b1);
            if (valid0_o) begin
                if (sb.size() == 0) check("strobe_expected_ch0", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    check("route_ch0", 0, e.ch);
                    check("data_ch0", data0_o, e.data);
                end
            end else check("idle_data0", data0_o, 8'h0);
            if (valid1_o) begin
                if (sb.size() == 0) check("strobe_expected_ch1", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    check("route_ch1", 1, e.ch);
                    check("data_ch1", data1_o, e.data);
                end
            end else check("idle_data1", data1_o, 8'h0);
            if (valid2_o) begin
                if (sb.size() == 0) check("strobe_expected_ch2", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    check("route_ch2", 2, e.ch);
                    check("data_ch2", data2_o, e.data);
                end
            end else check("idle_data2", data2_o, 8'h0);
        end
    end

    initial begin
        rst_n    = 1'b1;
        select_i = 2'd0;
        data_i   = 8'h0;
        valid_i  = 1'b0;
        busy0_i  = 1'b0;
        busy1_i  = 1'b0;
        busy2_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        quiet("reset");
        rst_n  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Channel 1 message with exact 2-cycle latency and 3-cycle burst
        @(posedge clk); #1;
        select_i = 2'd1; data_i = 8'h41; valid_i = 1'b1;
        sb.push_back('{ch: 2'd1, data: 8'h41});
        @(negedge clk) check("lat_c0", valid1_o, 1'b0);
        @(posedge clk); #1;
        data_i = 8'h42;
        sb.push_back('{ch: 2'd1, data: 8'h42});
        @(negedge clk) check("lat_c1", valid1_o, 1'b0);
        @(posedge clk); #1;
        data_i = T;
        sb.push_back('{ch: 2'd1, data: T});
        @(negedge clk) check("lat_c2", valid1_o, 1'b1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk) check("lat_c3", valid1_o, 1'b1);
        @(negedge clk) check("lat_c4", valid1_o, 1'b1);
        @(negedge clk) check("lat_c5", valid1_o, 1'b0);
        drain("msg1", 20);

        // Mid-message select change is ignored; next message takes new select
        put(2'd0, 8'h10, 1'b1, 2'd0);
        put(2'd2, 8'h11, 1'b1, 2'd0);
        put(2'd2, T,     1'b1, 2'd0);
        put(2'd2, 8'h20, 1'b1, 2'd2);
        put(2'd2, T,     1'b1, 2'd2);
        idle(1);
        drain("sticky_tag", 20);

        // Full buffer: busy_o after 4th write, 5th byte dropped
        busy2_i = 1'b1;
        put(2'd2, 8'h31, 1'b1, 2'd2);
        put(2'd2, 8'h32, 1'b1, 2'd2);
        put(2'd2, 8'h33, 1'b1, 2'd2);
        put(2'd2, T,     1'b1, 2'd2);
        check("busy_before_full", busy_o, 1'b0);
        put(2'd2, 8'h35, 1'b0, 2'd2);
        check("busy_full", busy_o, 1'b1);
        idle(1);
        check("busy_after_drop", busy_o, 1'b1);
        @(negedge clk) check("hold_ch2", valid2_o, 1'b0);
        idle(2);
        check("busy_held", busy_o, 1'b1);
        busy2_i = 1'b0;
        drain("full", 20);
        check("busy_released", busy_o, 1'b0);

        // Discard channel: no strobes, buffer drains
        put(2'd3, 8'h55, 1'b0, 2'd3);
        put(2'd3, T,     1'b0, 2'd3);
        idle(6);
        check("discard_busy", busy_o, 1'b0);
        put(2'd0, 8'h77, 1'b1, 2'd0);
        put(2'd0, T,     1'b1, 2'd0);
        idle(1);
        drain("after_discard", 20);

        // Reset mid-message flushes buffered bytes and in_msg
        busy0_i = 1'b1;
        put(2'd0, 8'h01, 1'b1, 2'd0);
        put(2'd0, 8'h02, 1'b1, 2'd0);
        put(2'd0, 8'h03, 1'b1, 2'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        rst_n   = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        quiet("midreset");
        busy0_i = 1'b0;
        idle(6);
        put(2'd1, 8'h66, 1'b1, 2'd1);
        put(2'd1, T,     1'b1, 2'd1);
        idle(1);
        drain("fresh_select", 20);

        // Head-of-line blocking: B on ch1 waits behind A on busy ch0
        busy0_i = 1'b1;
        put(2'd0, 8'hA1, 1'b1, 2'd0);
        put(2'd0, 8'hA2, 1'b1, 2'd0);
        put(2'd0, T,     1'b1, 2'd0);
        put(2'd1, 8'hB1, 1'b1, 2'd1);
        busy0_i = 1'b0;
        put(2'd1, T,     1'b1, 2'd1);
        idle(1);
        drain("hol", 30);

        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
